cc_bus_decode_latch: RTL and testbench
======================================

Name: cc_bus_decode_latch

Overview:
- Bus-control slice of the Crystal Castles core: 6502 address decoder plus the OUT1 addressable output latch (video/auto-increment control).
- Produces active-low chip selects and write strobes for DRAM bitmode, ROM, working RAM, NVRAM, inputs, POKEY I/O, scroll, watchdog, IRQ-ack, OUT0, OUT1 and colour RAM.
- Latches the 8 OUT1 control bits.
- Sits between the CPU bus (BA, BRWn, BD) and all peripheral blocks.

Parameters:
- none

Ports:
- clk  in  1  10 MHz system clock
- reset_n  in  1  asynchronous, active-low reset
- ce2H  in  1  CPU phase clock-enable (1 clk wide)
- ce2Hd  in  1  ce2H delayed one clk; write-strobe qualifier
- BA  in  16  CPU address
- BRWn  in  1  1=read, 0=write
- BD3  in  1  CPU data bit 3 (OUT1 latch data)
- NRn, ROM0n, ROM1n, ROM2n  out  1 each  ROM region / chip selects
- SRAMn, NVRAMn, IN0n, CIOn, SBUSn  out  1 each  level selects
- BITMDn, XCOORDn, YCOORDn  out  1 each  bitmode selects
- WDOGn, INTACKn, HSLDn, VSLDn, OUT0n, OUT1n, CRAMn, UARTn  out  1 each  write strobes
- AXn, AYn, XINCn, YINCn, PLAYER2, SIREn, STARTLED1, BUF1BUF2n  out  1 each  OUT1 latch bits

Behaviour:
Level selects (combinational from BA, all active-low unless noted):
- NRn active-HIGH for A000-FFFF.
- ROM0n: A000-BFFF. ROM1n: C000-DFFF. ROM2n: E000-FFFF.
- SRAMn: 8000-8FFF. NVRAMn: 9000-93FF. IN0n: 9400-97FF. CIOn: 9800-9BFF. SBUSn: 9000-9FFF.
- BITMDn: BA==0002.
- Outside its range each select is inactive (1); for NRn, inactive is 0.

Write strobes:
- Low for exactly one clk, on the clk where ce2Hd=1, BRWn=0 and the address matches. Otherwise 1.
- XCOORDn: BA==0000. YCOORDn: BA==0001.
- INTACKn: 9C00-9C7F or 9D80-9DFF.
- HSLDn: 9C80-9CFF. VSLDn: 9D00-9D7F.
- WDOGn: 9E00-9E7F. OUT0n: 9E80-9EFF. OUT1n: 9F00-9F7F. CRAMn: 9F80-9FFF.
- UARTn: reserved, tied 1.
- Reads of strobe-only regions assert nothing.

OUT1 latch (74LS259-style addressable latch):
- Register behaviour: on the clk where OUT1n=0, latch bit BA[2:0] takes BD3; the other bits hold.
- Bit mapping: 0 AXn, 1 AYn, 2 XINCn, 3 YINCn, 4 PLAYER2, 5 SIREn, 6 STARTLED1, 7 BUF1BUF2n.
- Output pins equal latch bits directly; no inversion.
- Async reset_n low: all 8 bits = 0 immediately, and all strobes = 1.
- Mirrors: address bits BA[6:3] ignored within 9F00-9F7F.
- Back-to-back writes to different bits each update independently.
- Reset asserted mid-write: the reset value wins.

Latency:
- Level selects: 0 clk.
- Strobes: registered-free but gated by ce2Hd.
- Latch outputs: change on the clk edge ending the OUT1n pulse.

Test Plan:
- Reset: reset_n=0 -> all 8 latch outputs 0, all strobes 1; NRn=0 for BA=0000.
- Address sweep, BRWn=1:
  - BA=A123 -> NRn=1, ROM0n=0.
  - C000 -> ROM1n=0. FFFC -> ROM2n=0.
  - 8E10 -> SRAMn=0. 9200 -> NVRAMn=0.
  - 9600 -> IN0n=0. 9A05 -> CIOn=0. 0002 -> BITMDn=0.
  - No strobe fires during the sweep.
- Write strobes: BRWn=0, pulse ce2Hd:
  - 9C80 -> HSLDn low exactly 1 clk.
  - 9D00 -> VSLDn. 9E00 -> WDOGn. 9D80 -> INTACKn. 9FA3 -> CRAMn.
  - 0000 -> XCOORDn. 0001 -> YCOORDn.
  - Without ce2Hd -> no strobe.
- OUT1 latch writes:
  - BA=9F04, BD3=1 -> PLAYER2=1, others unchanged.
  - BA=9F7F, BD3=1 (mirror) -> BUF1BUF2n=1.
  - BA=9F04, BD3=0 -> PLAYER2=0.
- Latch sequence: write bits 0..3 with BD3=1 -> AXn=AYn=XINCn=YINCn=1. Then assert reset_n mid-sequence -> all 0 asynchronously.
- Read to 9F00 (BRWn=1) with ce2Hd -> OUT1n stays 1, latch unchanged.

Source files
------------

// File: rtl/cc_bus_decode_latch.sv
// Crystal Castles bus-control slice: 6502 address decode, gated write strobes
// and the 74LS259-style OUT1 addressable latch for video/auto-increment control.
module cc_bus_decode_latch (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce2H,
  input  logic        ce2Hd,
  input  logic [15:0] BA,
  input  logic        BRWn,
  input  logic        BD3,
  output logic        NRn,
  output logic        ROM0n,
  output logic        ROM1n,
  output logic        ROM2n,
  output logic        SRAMn,
  output logic        NVRAMn,
  output logic        IN0n,
  output logic        CIOn,
  output logic        SBUSn,
  output logic        BITMDn,
  output logic        XCOORDn,
  output logic        YCOORDn,
  output logic        WDOGn,
  output logic        INTACKn,
  output logic        HSLDn,
  output logic        VSLDn,
  output logic        OUT0n,
  output logic        OUT1n,
  output logic        CRAMn,
  output logic        UARTn,
  output logic        AXn,
  output logic        AYn,
  output logic        XINCn,
  output logic        YINCn,
  output logic        PLAYER2,
  output logic        SIREn,
  output logic        STARTLED1,
  output logic        BUF1BUF2n
);

  logic       wr_en;
  logic       io_blk;
  logic [2:0] io_sel;
  logic [7:0] out1_d;
  logic [7:0] out1_q;

  // The CPU phase enable is not needed here; writes are qualified by ce2Hd alone.
  logic unused_ok;
  assign unused_ok = ce2H;

  // Level selects straight from the address bus.
  assign NRn    = BA[15] & (BA[14] | BA[13]);
  assign ROM0n  = ~(BA[15:13] == 3'b101);
  assign ROM1n  = ~(BA[15:13] == 3'b110);
  assign ROM2n  = ~(BA[15:13] == 3'b111);
  assign SRAMn  = ~(BA[15:12] == 4'h8);
  assign NVRAMn = ~(BA[15:10] == 6'b100100);
  assign IN0n   = ~(BA[15:10] == 6'b100101);
  assign CIOn   = ~(BA[15:10] == 6'b100110);
  assign SBUSn  = ~(BA[15:12] == 4'h9);
  assign BITMDn = ~(BA == 16'h0002);

  // 9C00-9FFF is split into eight 128-byte strobe windows by BA[9:7].
  assign wr_en  = ce2Hd & ~BRWn & reset_n;
  assign io_blk = (BA[15:10] == 6'b100111);
  assign io_sel = BA[9:7];

  assign XCOORDn = ~(wr_en & (BA == 16'h0000));
  assign YCOORDn = ~(wr_en & (BA == 16'h0001));
  assign INTACKn = ~(wr_en & io_blk & ((io_sel == 3'd0) | (io_sel == 3'd3)));
  assign HSLDn   = ~(wr_en & io_blk & (io_sel == 3'd1));
  assign VSLDn   = ~(wr_en & io_blk & (io_sel == 3'd2));
  assign WDOGn   = ~(wr_en & io_blk & (io_sel == 3'd4));
  assign OUT0n   = ~(wr_en & io_blk & (io_sel == 3'd5));
  assign OUT1n   = ~(wr_en & io_blk & (io_sel == 3'd6));
  assign CRAMn   = ~(wr_en & io_blk & (io_sel == 3'd7));
  assign UARTn   = 1'b1;

  // Only the bit addressed by BA[2:0] moves; BA[6:3] are don't-care mirrors.
  always_comb begin
    out1_d = out1_q;
    if (!OUT1n) begin
      out1_d[BA[2:0]] = BD3;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out1_q <= '0;
    end else begin
      out1_q <= out1_d;
    end
  end

  assign AXn       = out1_q[0];
  assign AYn       = out1_q[1];
  assign XINCn     = out1_q[2];
  assign YINCn     = out1_q[3];
  assign PLAYER2   = out1_q[4];
  assign SIREn     = out1_q[5];
  assign STARTLED1 = out1_q[6];
  assign BUF1BUF2n = out1_q[7];

endmodule

// File: tb/tb_cc_bus_decode_latch.sv
// Bench for cc_bus_decode_latch: decode vector table plus OUT1 latch and
// reset sequences, all expectations hand-computed.
module tb_cc_bus_decode_latch;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ce2H = 1'b0;
  logic ce2Hd = 1'b0;
  logic [15:0] BA = 16'h0000;
  logic BRWn = 1'b1;
  logic BD3 = 1'b0;

  logic NRn, ROM0n, ROM1n, ROM2n, SRAMn, NVRAMn, IN0n, CIOn, SBUSn, BITMDn;
  logic XCOORDn, YCOORDn, WDOGn, INTACKn, HSLDn, VSLDn, OUT0n, OUT1n, CRAMn, UARTn;
  logic AXn, AYn, XINCn, YINCn, PLAYER2, SIREn, STARTLED1, BUF1BUF2n;

  logic [9:0] sel_v, strb_v;
  logic [7:0] latch_v;

  int n_tests = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];

  // Clock/reset
  always #50 clk = ~clk;

  cc_bus_decode_latch dut (
    .clk(clk), .reset_n(reset_n), .ce2H(ce2H), .ce2Hd(ce2Hd),
    .BA(BA), .BRWn(BRWn), .BD3(BD3),
    .NRn(NRn), .ROM0n(ROM0n), .ROM1n(ROM1n), .ROM2n(ROM2n),
    .SRAMn(SRAMn), .NVRAMn(NVRAMn), .IN0n(IN0n), .CIOn(CIOn), .SBUSn(SBUSn),
    .BITMDn(BITMDn), .XCOORDn(XCOORDn), .YCOORDn(YCOORDn), .WDOGn(WDOGn),
    .INTACKn(INTACKn), .HSLDn(HSLDn), .VSLDn(VSLDn), .OUT0n(OUT0n),
    .OUT1n(OUT1n), .CRAMn(CRAMn), .UARTn(UARTn),
    .AXn(AXn), .AYn(AYn), .XINCn(XINCn), .YINCn(YINCn), .PLAYER2(PLAYER2),
    .SIREn(SIREn), .STARTLED1(STARTLED1), .BUF1BUF2n(BUF1BUF2n)
  );

  assign sel_v   = {NRn, ROM0n, ROM1n, ROM2n, SRAMn, NVRAMn, IN0n, CIOn, SBUSn, BITMDn};
  assign strb_v  = {XCOORDn, YCOORDn, WDOGn, INTACKn, HSLDn, VSLDn, OUT0n, OUT1n, CRAMn, UARTn};
  assign latch_v = {BUF1BUF2n, STARTLED1, SIREn, PLAYER2, YINCn, XINCn, AYn, AXn};

  typedef struct {
    logic [15:0] ba;
    logic        brwn;
    logic        ce;
    logic [9:0]  sel;
    logic [9:0]  strb;
  } vec_t;

  localparam logic [9:0] SEL_IDLE  = 10'b0111111111;
  localparam logic [9:0] STRB_IDLE = 10'b1111111111;

  vec_t vecs[22];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    @(negedge clk);
    ce2Hd = 1'b0;
    BRWn  = 1'b1;
    BD3   = 1'b0;
    BA    = 16'h0000;
  endtask

  // Driver: one bus cycle, decode checked while ce2Hd is high and again
  // one clk later to confirm the strobe lasted exactly one clk.
  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk);
    BA    = v.ba;
    BRWn  = v.brwn;
    ce2Hd = v.ce;
    #1;
    check($sformatf("sel[%0d] BA=%h", idx, v.ba), {6'd0, sel_v}, {6'd0, v.sel});
    check($sformatf("strb[%0d] BA=%h", idx, v.ba), {6'd0, strb_v}, {6'd0, v.strb});
    @(negedge clk);
    ce2Hd = 1'b0;
    #1;
    check($sformatf("strb_end[%0d] BA=%h", idx, v.ba), {6'd0, strb_v}, {6'd0, STRB_IDLE});
  endtask

  // Driver: OUT1 write; scoreboard pops the expected latch value after the edge.
  task automatic write_out1(input logic [15:0] addr, input logic d);
    logic [7:0] exp;
    @(negedge clk);
    BA    = addr;
    BRWn  = 1'b0;
    BD3   = d;
    ce2Hd = 1'b1;
    #1;
    check($sformatf("out1n_low BA=%h", addr), {15'd0, OUT1n}, 16'd0);
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check($sformatf("latch BA=%h d=%0b", addr, d), {8'd0, latch_v}, {8'd0, exp});
    bus_idle();
  endtask

  initial begin
    vecs[0]  = '{16'hA123, 1'b1, 1'b0, 10'b1011111111, STRB_IDLE};
    vecs[1]  = '{16'hC000, 1'b1, 1'b0, 10'b1101111111, STRB_IDLE};
    vecs[2]  = '{16'hFFFC, 1'b1, 1'b0, 10'b1110111111, STRB_IDLE};
    vecs[3]  = '{16'h8E10, 1'b1, 1'b0, 10'b0111011111, STRB_IDLE};
    vecs[4]  = '{16'h9200, 1'b1, 1'b0, 10'b0111101101, STRB_IDLE};
    vecs[5]  = '{16'h9600, 1'b1, 1'b0, 10'b0111110101, STRB_IDLE};
    vecs[6]  = '{16'h9A05, 1'b1, 1'b0, 10'b0111111001, STRB_IDLE};
    vecs[7]  = '{16'h0002, 1'b1, 1'b0, 10'b0111111110, STRB_IDLE};
    vecs[8]  = '{16'h9C80, 1'b0, 1'b1, 10'b0111111101, 10'b1111011111};
    vecs[9]  = '{16'h9D00, 1'b0, 1'b1, 10'b0111111101, 10'b1111101111};
    vecs[10] = '{16'h9E00, 1'b0, 1'b1, 10'b0111111101, 10'b1101111111};
    vecs[11] = '{16'h9D80, 1'b0, 1'b1, 10'b0111111101, 10'b1110111111};
    vecs[12] = '{16'h9FA3, 1'b0, 1'b1, 10'b0111111101, 10'b1111111101};
    vecs[13] = '{16'h0000, 1'b0, 1'b1, SEL_IDLE,       10'b0111111111};
    vecs[14] = '{16'h0001, 1'b0, 1'b1, SEL_IDLE,       10'b1011111111};
    vecs[15] = '{16'h9C10, 1'b0, 1'b1, 10'b0111111101, 10'b1110111111};
    vecs[16] = '{16'h9EFF, 1'b0, 1'b1, 10'b0111111101, 10'b1111110111};
    vecs[17] = '{16'h9C80, 1'b0, 1'b0, 10'b0111111101, STRB_IDLE};
    vecs[18] = '{16'h9E00, 1'b1, 1'b1, 10'b0111111101, STRB_IDLE};
    vecs[19] = '{16'h0000, 1'b1, 1'b1, SEL_IDLE,       STRB_IDLE};
    vecs[20] = '{16'h0002, 1'b0, 1'b1, 10'b0111111110, STRB_IDLE};
    vecs[21] = '{16'h9F80, 1'b1, 1'b1, 10'b0111111101, STRB_IDLE};

    // Reset with a would-be XCOORD write on the bus: nothing may strobe.
    BA = 16'h0000;
    BRWn = 1'b0;
    ce2Hd = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_latch", {8'd0, latch_v}, 16'd0);
    check("reset_strb", {6'd0, strb_v}, {6'd0, STRB_IDLE});
    check("reset_nrn", {15'd0, NRn}, 16'd0);
    @(negedge clk);
    ce2Hd = 1'b0;
    BRWn = 1'b1;
    reset_n = 1'b1;

    foreach (vecs[i]) apply_vec(vecs[i], i);
    #1;
    check("latch_after_table", {8'd0, latch_v}, 16'd0);

    // OUT1 latch writes including a mirror address.
    exp_q.push_back(8'h10); write_out1(16'h9F04, 1'b1);
    exp_q.push_back(8'h90); write_out1(16'h9F7F, 1'b1);
    exp_q.push_back(8'h80); write_out1(16'h9F04, 1'b0);

    // Back-to-back writes of bits 0..3.
    exp_q.push_back(8'h81); write_out1(16'h9F00, 1'b1);
    exp_q.push_back(8'h83); write_out1(16'h9F09, 1'b1);
    exp_q.push_back(8'h87); write_out1(16'h9F12, 1'b1);
    exp_q.push_back(8'h8F); write_out1(16'h9F23, 1'b1);

    // Reset asserted while an OUT1 write is in progress.
    @(negedge clk);
    BA = 16'h9F06;
    BRWn = 1'b0;
    BD3 = 1'b1;
    ce2Hd = 1'b1;
    #1;
    check("midwr_out1n", {15'd0, OUT1n}, 16'd0);
    #1;
    reset_n = 1'b0;
    #1;
    check("midwr_async_latch", {8'd0, latch_v}, 16'd0);
    check("midwr_async_strb", {6'd0, strb_v}, {6'd0, STRB_IDLE});
    @(posedge clk);
    #1;
    check("midwr_edge_latch", {8'd0, latch_v}, 16'd0);
    @(negedge clk);
    ce2Hd = 1'b0;
    BRWn = 1'b1;
    BD3 = 1'b0;
    reset_n = 1'b1;

    // Read of 9F00 with ce2Hd must not touch the latch.
    exp_q.push_back(8'h01); write_out1(16'h9F00, 1'b1);
    @(negedge clk);
    BA = 16'h9F00;
    BRWn = 1'b1;
    BD3 = 1'b0;
    ce2Hd = 1'b1;
    #1;
    check("rd_out1n", {15'd0, OUT1n}, 16'd1);
    @(posedge clk);
    #1;
    check("rd_latch", {8'd0, latch_v}, 16'h0001);
    bus_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
